fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Write-side arbiter for the async FIFO. It shares the single write port (winc/wdata into the write-pointer logic and the FIFO memory) among NREQ producers in the wclk domain.
- Round-robin grant with packet lock: a granted producer keeps the port until it delivers a beat with last asserted.
- Each producer uses a valid/ready handshake. Writes are back-pressured by wfull.

Parameters:
- DATASIZE, 8, data word width; matches the FIFO memory width.
- NREQ, 4, number of producers; legal range 2..16.
- IDW, $clog2(NREQ), width of the grant index.

Ports:
- wclk  in  1  write-domain clock; all state updates on its rising edge.
- wrst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-producer valid; bit i belongs to producer i.
- req_last  in  NREQ  per-producer end-of-packet flag; qualified by req_valid.
- req_data  in  NREQ*DATASIZE  producer i word is bits [i*DATASIZE +: DATASIZE].
- req_ready  out  NREQ  per-producer ready; a beat transfers when valid & ready.
- wfull  in  1  FIFO full flag from the write-pointer logic (wclk domain).
- winc  out  1  write strobe to the write-pointer logic and the memory write enable.
- wdata  out  DATASIZE  write data to the memory.
- gnt_active  out  1  a producer currently owns the port.
- gnt_id  out  IDW  index of the owning producer; holds its last value when idle.

Behaviour:
- Reset (async, wrst_n=0): state=IDLE, gnt_active=0, gnt_id=0, rr_ptr=0, req_ready=0, winc=0.
- Registered state: state {IDLE, LOCKED}, gnt_id, rr_ptr (highest-priority index).
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr and wrapping modulo NREQ.
  - Load gnt_id with that index and go to LOCKED. Arbitration latency is 1 cycle.
  - No transfer happens in IDLE; req_ready=0 and winc=0.
  - If no req_valid bit is set, stay in IDLE.
- LOCKED, combinational outputs:
  - gnt_active=1.
  - req_ready[i] = (i==gnt_id) & !wfull; all other bits are 0.
  - winc = req_valid[gnt_id] & !wfull.
  - wdata = req_data slice for gnt_id, driven whenever gnt_active=1; don't-care otherwise.
  - winc is never asserted while wfull=1.
- LOCKED, transitions:
  - On an accepted beat (winc=1) with req_last[gnt_id]=1: go to IDLE and set rr_ptr = (gnt_id+1) mod NREQ.
  - Otherwise stay in LOCKED.
  - If the owner drops req_valid mid-packet, the lock holds indefinitely; other producers wait.
- Packet rules:
  - A packet of N beats occupies N accepted cycles plus 1 arbitration cycle.
  - There is always exactly one IDLE cycle between packets, including back-to-back packets from the same producer.
  - Single-beat packet (valid and last together on the first beat) is legal.
- wfull: while wfull=1 in LOCKED, the beat stalls; req_ready=0 and state, gnt_id and rr_ptr are unchanged.
- Wrap-around: rr_ptr wraps NREQ-1 -> 0. The search wraps, so the owner of the previous grant has the lowest priority next.
- Simultaneous events: a request raised in the same cycle another producer's last beat completes is seen in the following IDLE cycle.
- Reset mid-packet: the lock is dropped immediately and rr_ptr returns to 0. A partial packet already written stays in the FIFO; producers resend.
- Protocol requirement on producers: hold data and last stable while valid & !ready. Violations are not checked.

Test Plan:
- Single packet: reset, NREQ=4, producer 2 sends 3 beats 0x11,0x22,0x33 with last on 0x33, wfull=0.
  - Expect gnt_id=2 one cycle after valid rises.
  - Expect winc=1 on 3 consecutive cycles with wdata 0x11,0x22,0x33, then IDLE; rr_ptr=3.
- Round-robin: all four producers continuously valid, each sending 1-beat packets.
  - Expect grant order 0,1,2,3,0,1.
  - Expect one winc every 2 cycles, and no producer granted twice before all others are served.
- Packet lock: producer 0 sends 4 beats; producer 1 is valid throughout; producer 0 drops valid for 2 cycles after beat 2.
  - Expect gnt_id to stay 0 through all 4 beats and producer 1 to see req_ready=0.
  - Expect producer 1 granted only after producer 0's last beat.
- Full back-pressure: force wfull=1 for 3 cycles mid-packet while the owner stays valid.
  - Expect winc=0 and req_ready=0 during those 3 cycles, with no data lost or duplicated.
  - Expect the write to resume with the same held word.
- Wrap priority: rr_ptr=3 after producer 2 finishes; producers 0 and 3 then request together.
  - Expect producer 3 granted first, then producer 0.
- Async reset: assert wrst_n low for 1 cycle mid-packet from producer 1.
  - Expect winc, req_ready and gnt_active to drop to 0 immediately, with state IDLE and rr_ptr=0.
  - After release, with producers 1 and 2 requesting, expect producer 1 granted.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: write-side arbiter for the async FIFO.
// Shares the single write port (winc/wdata) among NREQ producers in the
// wclk domain using round-robin arbitration with packet lock. A granted
// producer owns the port until a beat with last set is accepted.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no owner; pick next requester from rr_ptr, no transfer
//   LOCKED | gnt_id owns the port; beats pass when valid and !wfull
module fifo_wr_arb #(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic                     gnt_active,
  output logic [IDW-1:0]           gnt_id
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic           any_valid;
  logic [IDW-1:0] pick_idx;
  logic [IDW:0]   cand;
  logic           owner_valid;
  logic           owner_last;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    any_valid = 1'b0;
    pick_idx  = rr_ptr_q;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!any_valid && req_valid[cand[IDW-1:0]]) begin
        any_valid = 1'b1;
        pick_idx  = cand[IDW-1:0];
      end
    end
  end

  // Owner's handshake signals and write data mux.
  always_comb begin
    owner_valid = req_valid[gnt_id_q];
    owner_last  = req_last[gnt_id_q];
    wdata       = req_data[gnt_id_q*DATASIZE +: DATASIZE];
  end

  // Next-state and output decode; wfull stalls the owner without changing state.
  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    winc       = 1'b0;
    req_ready  = '0;
    gnt_active = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          gnt_id_d = pick_idx;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        gnt_active = 1'b1;
        winc       = owner_valid & ~wfull;
        for (int i = 0; i < NREQ; i++) begin
          req_ready[i] = (IDW'(i) == gnt_id_q) & ~wfull;
        end
        // Last beat releases the lock; the finishing owner drops to lowest priority.
        if (winc && owner_last) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_id_q == IDW'(NREQ-1)) ? '0 : gnt_id_q + IDW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, owner and priority-pointer registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb: producers are packet queues, a reference
// arbiter model predicts each cycle's outputs and pushes expected writes
// into a scoreboard queue that a separate monitor drains on winc.
module tb_fifo_wr_arb;
  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int DEPTH = 4096;

  logic            wclk = 1'b0;
  logic            wrst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wfull;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic            gnt_active;
  logic [IW-1:0]   gnt_id;

  fifo_wr_arb #(.DATASIZE(DW), .NREQ(N), .IDW(IW)) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wfull      (wfull),
    .winc       (winc),
    .wdata      (wdata),
    .gnt_active (gnt_active),
    .gnt_id     (gnt_id)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Producer beat storage
  int bdat  [N][DEPTH];
  bit blast [N][DEPTH];
  int wr_p  [N];
  int rd_p  [N];
  int pkt_s [N];

  // Scoreboard: owner*256 + data
  int exp_q [$];

  // Reference model state: is some producer locked, who, and who has top priority
  bit m_lock;
  int m_owner;
  int m_rr;

  int vprob;
  int fprob;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_beat(input int p, input int d, input bit l);
    bdat[p][wr_p[p]]  = d;
    blast[p][wr_p[p]] = l;
    wr_p[p]++;
  endtask

  task automatic add_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) add_beat(p, int'($urandom_range(0, 255)), b == len - 1);
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      bit has;
      has = rd_p[p] < wr_p[p];
      req_valid[p] = has && ($urandom_range(0, 99) < vprob);
      req_data[p*DW +: DW] = has ? DW'(bdat[p][rd_p[p]]) : DW'($urandom_range(0, 255));
      req_last[p] = has ? blast[p][rd_p[p]] : 1'($urandom_range(0, 1));
    end
    wfull = ($urandom_range(0, 99) < fprob);
  endtask

  task automatic model_step();
    int exp_ready;
    int exp_winc;
    exp_ready = 0;
    exp_winc  = 0;
    if (m_lock) begin
      if (!wfull) exp_ready = 1 << m_owner;
      exp_winc = (req_valid[m_owner] && !wfull) ? 1 : 0;
    end
    chk("gnt_active", int'(gnt_active), int'(m_lock));
    chk("gnt_id", int'(gnt_id), m_owner);
    chk("req_ready", int'(req_ready), exp_ready);
    chk("winc", int'(winc), exp_winc);
    if (exp_winc != 0) exp_q.push_back(m_owner * 256 + int'(req_data[m_owner*DW +: DW]));
    // producers consume on the handshake they actually observe
    for (int p = 0; p < N; p++) begin
      if (req_valid[p] && req_ready[p]) begin
        if (blast[p][rd_p[p]]) pkt_s[p] = rd_p[p] + 1;
        rd_p[p]++;
      end
    end
    if (!m_lock) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!m_lock && req_valid[idx]) begin
          m_lock  = 1'b1;
          m_owner = idx;
        end
      end
    end else if (exp_winc != 0 && req_last[m_owner]) begin
      m_lock = 1'b0;
      m_rr   = (m_owner + 1) % N;
    end
  endtask

  task automatic one_cycle();
    @(posedge wclk);
    #1;
    drive_inputs();
    @(negedge wclk);
    model_step();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) one_cycle();
  endtask

  // Async reset in the middle of a cycle; outputs must drop without a clock edge.
  task automatic reset_pulse();
    @(posedge wclk);
    #1;
    drive_inputs();
    #2;
    wrst_n = 1'b0;
    #1;
    chk("rst_winc", int'(winc), 0);
    chk("rst_gnt_active", int'(gnt_active), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    m_lock  = 1'b0;
    m_owner = 0;
    m_rr    = 0;
    exp_q.delete();
    for (int p = 0; p < N; p++) rd_p[p] = pkt_s[p];
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    drive_inputs();
    @(negedge wclk);
    model_step();
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int p = 0; p < N; p++) s += wr_p[p] - rd_p[p];
    return s;
  endfunction

  // Monitor: every DUT write must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge wclk);
      #2;
      if (winc === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_unexpected: got write id %0d data %0h, expected no write at %0t",
                   gnt_id, wdata, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("wr_id_data", int'(gnt_id) * 256 + int'(wdata), e);
        end
      end
    end
  end

  initial begin
    int budget;
    for (int p = 0; p < N; p++) begin
      wr_p[p]  = 0;
      rd_p[p]  = 0;
      pkt_s[p] = 0;
    end
    m_lock    = 1'b0;
    m_owner   = 0;
    m_rr      = 0;
    vprob     = 100;
    fprob     = 0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    chk("reset_gnt_active", int'(gnt_active), 0);
    chk("reset_winc", int'(winc), 0);
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_gnt_id", int'(gnt_id), 0);
    wrst_n = 1'b1;

    // single 3-beat packet from producer 2
    add_beat(2, 8'h11, 1'b0);
    add_beat(2, 8'h22, 1'b0);
    add_beat(2, 8'h33, 1'b1);
    run(6);

    // round robin with single-beat packets from everyone
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) add_beat(p, 16 * p + r, 1'b1);
    run(20);

    // packet lock with the owner dropping valid now and then
    add_pkt(0, 4);
    add_pkt(1, 2);
    vprob = 60;
    run(40);

    // back-pressure mid-packet
    vprob = 100;
    fprob = 40;
    add_pkt(3, 5);
    run(30);

    // wrap priority: after producer 2, producers 0 and 3 request together
    fprob = 0;
    add_pkt(2, 2);
    run(6);
    add_beat(0, 8'hA0, 1'b1);
    add_beat(3, 8'hA3, 1'b1);
    run(8);

    // reset mid-packet from producer 1, then 1 and 2 compete
    add_pkt(1, 4);
    run(3);
    add_pkt(2, 2);
    reset_pulse();
    run(15);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        vprob = int'($urandom_range(50, 100));
        fprob = int'($urandom_range(0, 40));
      end
      for (int p = 0; p < N; p++)
        if (rd_p[p] == wr_p[p] && wr_p[p] < DEPTH - 20 && $urandom_range(0, 3) == 0)
          add_pkt(p, int'($urandom_range(1, 5)));
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else one_cycle();
    end

    // drain everything outstanding
    vprob  = 100;
    fprob  = 0;
    budget = 0;
    while (pending() > 0 && budget < 1000) begin
      one_cycle();
      budget++;
    end
    chk("drain_pending", pending(), 0);
    run(3);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
